seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Transmit side of the hex-digit/LE/point interface consumed by our MC14495-style 7-segment decoder.
- Holds a 4-digit hex value in a shadow register. Time-multiplexes one digit at a time onto the decoder inputs and drives active-low digit anodes.
- Sits between the datapath (which supplies the 16-bit value) and the decoder plus board display.

Parameters:
- DIV_W, 17, scan-slot length is 2^DIV_W clk cycles; legal range 2..24.
- BLANK_CYC, 4, anti-ghost cycles at the start of each slot with all anodes off; must be < 2^DIV_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- data  in  16  hex value; digit i = data[4i+3:4i]
- points  in  4  decimal-point request per digit; 1 = dot lit
- le_mask  in  4  per-digit blank request; 1 = digit dark
- lzb_en  in  1  leading-zero blanking enable
- load  in  1  capture strobe for data/points/le_mask/lzb_en
- hex  out  4  digit code to decoder D3..D0
- le  out  1  decoder LE; 1 = all segments off
- point  out  1  decoder point input; 1 = dot lit
- an  out  4  digit anodes, active-low
- frame  out  1  one-cycle pulse on slot-3 to slot-0 wrap

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high (rst). Asserting rst mid-slot forces all state and outputs to reset values immediately, with no clk edge needed.
- Reset values:
  - div_cnt=0, idx=0.
  - Shadow: data 0, points 0, le_mask 4'hF, lzb 0.
  - Outputs: hex=0, le=1, point=0, an=4'b1111, frame=0.
- Load:
  - When load=1 at a posedge, the shadow registers capture data, points, le_mask and lzb_en.
  - load held high recaptures every cycle.
  - A capture is visible on the outputs from the following cycle's output register update, i.e. 2-cycle latency from the load edge to the outputs.
  - Mid-slot capture is legal and changes the current digit immediately; no slot restart.
- Divider:
  - div_cnt (DIV_W bits) increments every cycle and wraps from 2^DIV_W-1 to 0.
  - On that wrap, idx advances 0→1→2→3→0.
  - On the 3→0 wrap, frame is registered high for exactly one cycle.
- Output registers: all outputs are registered and computed from the current div_cnt, idx and shadow, so outputs lag state by 1 cycle.
  - If div_cnt < BLANK_CYC: an=4'b1111, le=1, point=0, hex=shadow nibble[idx].
  - Otherwise:
    - an = ~(4'b0001 << idx)
    - hex = shadow nibble[idx]
    - point = shadow points[idx]
    - le = shadow le_mask[idx] | lzb_blank(idx)
- Leading-zero blanking:
  - lzb_blank(i)=1 iff lzb=1, i≠0, and all shadow nibbles i..3 are zero.
  - Digit 0 is never LZB-blanked.
  - The decimal point is not suppressed by LZB.
- Exactly one anode is low outside blank cycles; never more than one at any time.
- No handshake back-pressure: load is fire-and-forget.

Decomposition:
- Shared package seg7_pkg:
  - NUM_DIGITS=4
  - AN_ALL_OFF=4'b1111
  - digit-index typedef (2 bits)
- Sub-module seg7_scan_timer: holds div_cnt/idx/frame and exports idx plus in_blank.
- Top-level seg7_scan_driver holds the shadow registers, LZB logic and output registers.

Test Plan (DIV_W=3, BLANK_CYC=1, 8-cycle slots):
- Reset: assert rst asynchronously between edges → an=1111, le=1, hex=0, point=0 on the same cycle; release → first slot shows idx 0 after 1 blank cycle.
- Scan: load data=16'h1234, le_mask=0, points=4'b0100 → per slot, after its blank cycle:
  - slot 0: an=1110, hex=4
  - slot 1: an=1101, hex=3
  - slot 2: an=1011, hex=2, point=1
  - slot 3: an=0111, hex=1
  - frame pulses once per 32 cycles at the 3→0 wrap.
- Blank cycles: in every slot, cycle 0 shows an=1111 and le=1; no cycle ever has two anodes low.
- LZB: data=16'h0050, lzb_en=1 → digits 3 and 2 show le=1, digits 1 and 0 show le=0 (hex 5, 0); data=16'h0000 → only digit 0 has le=0, hex=0.
- Mid-slot load: during slot 1, cycle 4, load data=16'hABCD → from cycle 6 of the same slot, hex=C with no idx change.
- le_mask=4'b1010 with data=16'hFFFF → digits 1 and 3 have le=1; digits 0 and 2 have le=0, hex=F.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   NUM_DIGITS  : number of multiplexed digits on the board display
//   AN_ALL_OFF  : anode pattern with every digit dark (anodes are active-low)
//   digit_idx_t : index of the digit currently being scanned
//   anode_for   : active-low one-hot anode pattern for a digit index
//   lzb_blank   : leading-zero blanking decision for a digit index
package seg7_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    function automatic logic [3:0] anode_for(input digit_idx_t i);
        return ~(4'b0001 << i);
    endfunction

    // A digit is a leading zero when it and every more significant digit are
    // zero. Digit 0 always stays lit so a value of zero still shows "0".
    function automatic logic lzb_blank(input logic        lzb,
                                       input logic [15:0] d,
                                       input digit_idx_t  i);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((k >= int'(i)) && (d[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        return lzb && (i != 2'd0) && upper_zero;
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Scan timing for the 7-segment driver.
// Splits time into slots of 2^DIV_W clk cycles, one slot per digit, and
// walks the digit index 0->1->2->3->0 at every slot boundary.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   idx      : digit index of the current slot
//   in_blank : high during the first BLANK_CYC cycles of a slot
//   frame    : one-cycle registered pulse when the scan wraps from digit 3 to 0
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int DIV_W     = 17,
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] idx,
    output logic       in_blank,
    output logic       frame
);

    localparam logic [DIV_W-1:0] DIV_MAX   = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);

    logic [DIV_W-1:0] div_cnt;
    digit_idx_t       idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx_q   <= '0;
            frame   <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            frame   <= 1'b0;
            if (div_cnt == DIV_MAX) begin
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    frame <= 1'b1;
                end
            end
        end
    end

    assign idx      = idx_q;
    assign in_blank = (div_cnt < BLANK_LIM);

endmodule

// File: rtl/seg7_scan_driver.sv
// Transmit side of the hex/LE/point interface to an MC14495-style decoder.
// Captures a 4-digit hex value with per-digit point and blank requests, then
// scans one digit at a time onto the decoder inputs while driving the
// matching active-low anode. Each slot starts with a few cycles where all
// anodes are off so the previous digit does not ghost onto the next one.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   data    : hex value, digit i = data[4i+3:4i]
//   points  : per-digit decimal point request (1 = lit)
//   le_mask : per-digit blank request (1 = dark)
//   lzb_en  : leading-zero blanking enable
//   load    : capture strobe for data/points/le_mask/lzb_en
//   hex     : digit code to decoder D3..D0
//   le      : decoder latch-enable / blank (1 = all segments off)
//   point   : decoder point input (1 = dot lit)
//   an      : digit anodes, active-low
//   frame   : one-cycle pulse when the scan wraps from digit 3 to digit 0
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV_W     = 17,
    parameter int BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic [3:0]  points,
    input  logic [3:0]  le_mask,
    input  logic        lzb_en,
    input  logic        load,
    output logic [3:0]  hex,
    output logic        le,
    output logic        point,
    output logic [3:0]  an,
    output logic        frame
);

    logic [1:0]  idx;
    logic        in_blank;

    logic [15:0] sh_data;
    logic [3:0]  sh_points;
    logic [3:0]  sh_le_mask;
    logic        sh_lzb;

    logic [3:0]  cur_nib;
    logic        cur_le;

    seg7_scan_timer #(
        .DIV_W     (DIV_W),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .idx      (idx),
        .in_blank (in_blank),
        .frame    (frame)
    );

    // Shadow registers; a capture takes effect on the very next output update,
    // so a mid-slot load changes the current digit without restarting the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_data    <= 16'h0000;
            sh_points  <= 4'h0;
            sh_le_mask <= 4'hF;
            sh_lzb     <= 1'b0;
        end else if (load) begin
            sh_data    <= data;
            sh_points  <= points;
            sh_le_mask <= le_mask;
            sh_lzb     <= lzb_en;
        end
    end

    assign cur_nib = sh_data[{idx, 2'b00} +: 4];
    assign cur_le  = sh_le_mask[idx] | lzb_blank(sh_lzb, sh_data, idx);

    // Output registers: one cycle behind the timer and shadow state.
    // The hex code keeps following the digit during blank cycles so the
    // decoder inputs are already settled when the anode turns on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex   <= 4'h0;
            le    <= 1'b1;
            point <= 1'b0;
            an    <= AN_ALL_OFF;
        end else if (in_blank) begin
            hex   <= cur_nib;
            le    <= 1'b1;
            point <= 1'b0;
            an    <= AN_ALL_OFF;
        end else begin
            hex   <= cur_nib;
            le    <= cur_le;
            point <= sh_points[idx];
            an    <= anode_for(idx);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  points;
    logic [3:0]  le_mask;
    logic        lzb_en;
    logic        load;
    logic [3:0]  hex;
    logic        le;
    logic        point;
    logic [3:0]  an;
    logic        frame;

    int total;
    int bad;
    int ecnt;

    seg7_scan_driver #(
        .DIV_W     (3),
        .BLANK_CYC (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .points  (points),
        .le_mask (le_mask),
        .lzb_en  (lzb_en),
        .load    (load),
        .hex     (hex),
        .le      (le),
        .point   (point),
        .an      (an),
        .frame   (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; after edge n the outputs show div_cnt=(n-1)%8
    // of slot ((n-1)/8)%4.
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_vals(input logic [15:0] d, input logic [3:0] p,
                             input logic [3:0] m, input logic z);
        data = d; points = p; le_mask = m; lzb_en = z; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_to(input int n);
        int guard;
        guard = 0;
        while (ecnt < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (ecnt !== n) begin
            $display("FAIL wait_to: ecnt=%0d required=%0d", ecnt, n);
            bad++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        load_vals(16'h1234, 4'hF, 4'h0, 1'b0);
        wait_to(12);
        // Assert reset between edges; outputs must clear with no clock edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({an, le, hex, point, frame} !== {4'b1111, 1'b1, 4'h0, 1'b0, 1'b0}) begin
            $display("FAIL async_reset: an=%b le=%b hex=%h point=%b frame=%b required an=1111 le=1 hex=0 point=0 frame=0",
                     an, le, hex, point, frame);
            bad++;
        end
        @(negedge clk);
        rst = 1'b0;
        wait_to(1);
        total++;
        if (an !== 4'b1111 || le !== 1'b1) begin
            $display("FAIL reset_first_blank: an=%b le=%b required an=1111 le=1", an, le);
            bad++;
        end
        wait_to(2);
        // Shadow le_mask resets to all-dark, data to zero.
        total++;
        if (an !== 4'b1110 || le !== 1'b1 || hex !== 4'h0 || point !== 1'b0) begin
            $display("FAIL reset_slot0: an=%b le=%b hex=%h point=%b required an=1110 le=1 hex=0 point=0",
                     an, le, hex, point);
            bad++;
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an [4];
        logic [3:0] exp_hex[4];
        logic       exp_pt [4];
        int         nframe;
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_hex = '{4'h4, 4'h3, 4'h2, 4'h1};
        exp_pt  = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        load_vals(16'h1234, 4'b0100, 4'b0000, 1'b0);
        for (int s = 0; s < 4; s++) begin
            wait_to(8*s + 4);
            total++;
            if (an !== exp_an[s] || hex !== exp_hex[s] || point !== exp_pt[s] || le !== 1'b0) begin
                $display("FAIL scan_slot%0d: an=%b hex=%h point=%b le=%b required an=%b hex=%h point=%b le=0",
                         s, an, hex, point, le, exp_an[s], exp_hex[s], exp_pt[s]);
                bad++;
            end
        end
        wait_to(31);
        total++;
        if (frame !== 1'b0) begin
            $display("FAIL frame_before_wrap: frame=%b required 0", frame);
            bad++;
        end
        wait_to(32);
        total++;
        if (frame !== 1'b1) begin
            $display("FAIL frame_at_wrap: frame=%b required 1", frame);
            bad++;
        end
        nframe = 1;
        for (int i = 33; i <= 96; i++) begin
            wait_to(i);
            if (frame === 1'b1) nframe++;
        end
        total++;
        if (nframe !== 3) begin
            $display("FAIL frame_count: pulses=%0d required 3", nframe);
            bad++;
        end
    endtask

    task automatic test_blank();
        int bad_blank;
        int multi;
        bad_blank = 0;
        multi = 0;
        do_reset();
        load_vals(16'h89AB, 4'hF, 4'h0, 1'b0);
        for (int i = 2; i <= 65; i++) begin
            wait_to(i);
            if ($countones(~an) > 1) multi++;
            if (((i - 1) % 8) == 0 && (an !== 4'b1111 || le !== 1'b1 || point !== 1'b0)) bad_blank++;
            if (((i - 1) % 8) != 0 && $countones(~an) != 1) bad_blank++;
        end
        total++;
        if (multi !== 0) begin
            $display("FAIL multi_anode: cycles=%0d required 0", multi);
            bad++;
        end
        total++;
        if (bad_blank !== 0) begin
            $display("FAIL blank_cycles: wrong_cycles=%0d required 0", bad_blank);
            bad++;
        end
    endtask

    task automatic test_lzb();
        logic       exp_le [4];
        logic [3:0] exp_hex[4];
        exp_le  = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_hex = '{4'h0, 4'h5, 4'h0, 4'h0};
        do_reset();
        load_vals(16'h0050, 4'b0000, 4'b0000, 1'b1);
        for (int s = 0; s < 4; s++) begin
            wait_to(8*s + 5);
            total++;
            if (le !== exp_le[s] || hex !== exp_hex[s]) begin
                $display("FAIL lzb_0050_d%0d: le=%b hex=%h required le=%b hex=%h",
                         s, le, hex, exp_le[s], exp_hex[s]);
                bad++;
            end
        end
        do_reset();
        load_vals(16'h0000, 4'b1000, 4'b0000, 1'b1);
        for (int s = 0; s < 4; s++) begin
            wait_to(8*s + 5);
            total++;
            if (le !== (s != 0) || hex !== 4'h0 || point !== (s == 3)) begin
                $display("FAIL lzb_0000_d%0d: le=%b hex=%h point=%b required le=%b hex=0 point=%b",
                         s, le, hex, point, (s != 0), (s == 3));
                bad++;
            end
        end
    endtask

    task automatic test_mid_slot_load();
        do_reset();
        load_vals(16'h1234, 4'b0000, 4'b0000, 1'b0);
        wait_to(12);
        load_vals(16'hABCD, 4'b0000, 4'b0000, 1'b0);
        total++;
        if (hex !== 4'h3 || an !== 4'b1101) begin
            $display("FAIL midload_before: hex=%h an=%b required hex=3 an=1101", hex, an);
            bad++;
        end
        wait_to(14);
        total++;
        if (hex !== 4'hC || an !== 4'b1101) begin
            $display("FAIL midload_after: hex=%h an=%b required hex=c an=1101", hex, an);
            bad++;
        end
        wait_to(16);
        total++;
        if (hex !== 4'hC || an !== 4'b1101 || le !== 1'b0) begin
            $display("FAIL midload_slot_end: hex=%h an=%b le=%b required hex=c an=1101 le=0", hex, an, le);
            bad++;
        end
        wait_to(18);
        total++;
        if (hex !== 4'hB || an !== 4'b1011) begin
            $display("FAIL midload_next_slot: hex=%h an=%b required hex=b an=1011", hex, an);
            bad++;
        end
    endtask

    task automatic test_le_mask();
        do_reset();
        load_vals(16'hFFFF, 4'b0000, 4'b1010, 1'b0);
        for (int s = 0; s < 4; s++) begin
            wait_to(8*s + 3);
            total++;
            if (le !== s[0] || hex !== 4'hF) begin
                $display("FAIL le_mask_d%0d: le=%b hex=%h required le=%b hex=f", s, le, hex, s[0]);
                bad++;
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        data = 16'h0000;
        points = 4'h0;
        le_mask = 4'h0;
        lzb_en = 1'b0;
        load = 1'b0;
        @(negedge clk);
        test_reset();
        test_scan();
        test_blank();
        test_lzb();
        test_mid_slot_load();
        test_le_mask();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
